mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and starvation limit.
package mem_arbiter_pkg;

  typedef enum logic {
    NORM     = 1'b0,
    EXT_RESP = 1'b1
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (zero latency) and a secondary
// loader/debug port (one-cycle acked), with a starvation bound on the secondary port.
//
// state    | meaning
// NORM     | ext may be granted; CPU grants count toward the starvation bound
// EXT_RESP | ext_ack pulses; ext is not granted, CPU may be
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ack,
  output logic [31:0] ext_rdata,
  output logic        ext_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             ext_armed;
  logic             ext_misaligned;
  logic             ext_elig;
  logic             grant_ext;
  logic             grant_cpu;

  assign ext_misaligned = (ext_addr[1:0] != 2'b00);
  // ext_armed blocks re-serving a request that stayed high past its ack
  assign ext_elig       = ext_req && (state == NORM) && ext_armed;
  assign grant_ext      = ext_elig && (!cpu_req || (starve_cnt == CNT_MAX));
  assign grant_cpu      = cpu_req && !grant_ext;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_we    = 1'b0;
    if (grant_ext) begin
      dm_addr  = ext_addr;
      dm_wdata = ext_wdata;
      dm_we    = ext_we && !ext_misaligned;
    end else if (grant_cpu) begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_we    = cpu_we;
    end
    if (!reset) dm_we = 1'b0;
  end

  assign cpu_rdata = grant_cpu ? dm_rdata : '0;
  assign cpu_stall = cpu_req && !grant_cpu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORM;
      starve_cnt <= '0;
      ext_armed  <= 1'b1;
      ext_ack    <= 1'b0;
      ext_err    <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        NORM:     state <= grant_ext ? EXT_RESP : NORM;
        EXT_RESP: state <= NORM;
        default:  state <= NORM;
      endcase

      ext_ack   <= grant_ext;
      ext_err   <= grant_ext && ext_misaligned;
      ext_rdata <= (grant_ext && !ext_misaligned) ? dm_rdata : '0;

      if (!ext_req)       ext_armed <= 1'b1;
      else if (grant_ext) ext_armed <= 1'b0;

      if (grant_ext || !ext_req)
        starve_cnt <= '0;
      else if (grant_cpu && (state == NORM) && (starve_cnt != CNT_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural arbitration model predicts each cycle,
// a separate monitor compares the DUT on the falling clock edge.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_ack, ext_err;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'h0A50_0000 ^ (32'(i) * 32'h0101_0107);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Environment memory: combinational read, write on the clock edge
  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr[9:2]];

  typedef struct {
    logic        stall, we, ack;
    logic [31:0] addr, wdata, rdata;
  } cyc_exp_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } ext_exp_t;

  cyc_exp_t cyc_q[$];
  ext_exp_t ext_q[$];
  cyc_exp_t me;
  ext_exp_t mx;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction served per cycle, priority by the starvation rule
  bit          m_in_resp, m_armed, last_ack, last_stall;
  int          m_cnt;
  logic [31:0] m_mem [256];

  task automatic model_cycle();
    cyc_exp_t e;
    ext_exp_t x;
    bit g_ext, g_cpu, mis;
    mis   = (ext_addr % 4) != 0;
    g_ext = ext_req && !m_in_resp && m_armed && (!cpu_req || m_cnt == STARVE);
    g_cpu = cpu_req && !g_ext;
    e.ack   = m_in_resp;
    e.stall = cpu_req && !g_cpu;
    e.rdata = g_cpu ? m_mem[widx(cpu_addr)] : 32'd0;
    e.we    = g_cpu ? cpu_we : (g_ext ? (ext_we && !mis) : 1'b0);
    e.addr  = g_cpu ? cpu_addr : (g_ext ? ext_addr : 32'd0);
    e.wdata = g_cpu ? cpu_wdata : (g_ext ? ext_wdata : 32'd0);
    cyc_q.push_back(e);
    if (g_ext) begin
      x.err   = mis;
      x.rdata = mis ? 32'd0 : m_mem[widx(ext_addr)];
      ext_q.push_back(x);
    end
    if (e.we) m_mem[widx(e.addr)] = e.wdata;
    if (!ext_req) m_armed = 1;
    else if (g_ext) m_armed = 0;
    if (g_ext || !ext_req) m_cnt = 0;
    else if (g_cpu && !m_in_resp && m_cnt < STARVE) m_cnt++;
    m_in_resp  = g_ext;
    last_ack   = e.ack;
    last_stall = e.stall;
  endtask

  task automatic model_reset();
    m_in_resp = 0; m_armed = 1; m_cnt = 0; last_ack = 0; last_stall = 0;
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (cyc_q.size() != 0) begin
        me = cyc_q.pop_front();
        chk1("cpu_stall", cpu_stall, me.stall);
        chk1("dm_we", dm_we, me.we);
        chk("dm_addr", dm_addr, me.addr);
        chk("dm_wdata", dm_wdata, me.wdata);
        chk("cpu_rdata", cpu_rdata, me.rdata);
        chk1("ext_ack", ext_ack, me.ack);
      end
      if (ext_ack === 1'b1) begin
        if (ext_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ext_ack_unexpected: got ack, expected none (t=%0t)", $time);
        end else begin
          mx = ext_q.pop_front();
          chk1("ext_err", ext_err, mx.err);
          chk("ext_rdata", ext_rdata, mx.rdata);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit exp_stall [13];
    bit ext_done;
    exp_stall = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    ext_done  = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    model_reset();

    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'hFFFF_FFFF;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    chk1("rst_ext_ack", ext_ack, 1'b0);
    chk1("rst_ext_err", ext_err, 1'b0);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk1("rst_dm_we", dm_we, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // CPU store then load, no stalls
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; #1;
    chk1("cpu_st_stall", cpu_stall, 1'b0);
    tick();
    cpu_we = 0; #1;
    chk1("cpu_ld_stall", cpu_stall, 1'b0);
    chk("cpu_ld_data", cpu_rdata, 32'hDEAD_BEEF);
    tick();
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    tick();

    // Ext read, one-cycle ack, then a held request must not be re-served
    cpu_req = 0; cpu_we = 0;
    ext_req = 1; ext_we = 0; ext_addr = 32'h20; #1;
    chk("ext_grant_addr", dm_addr, 32'h20);
    tick();
    chk1("ext_rd_ack", ext_ack, 1'b1);
    chk("ext_rd_data", ext_rdata, 32'h1234_5678);
    chk("ext_resp_nogrant", dm_addr, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("collision_nogrant", dm_addr, 32'h0);
      tick();
    end
    ext_req = 0;
    tick();
    ext_req = 1; #1;
    chk("rearm_grant", dm_addr, 32'h20);
    tick();
    tick();
    ext_req = 0;
    tick();

    // Misaligned ext write: acked with error, memory untouched
    ext_req = 1; ext_we = 1; ext_addr = 32'h23; ext_wdata = 32'hFFFF_FFFF; #1;
    chk1("mis_dm_we", dm_we, 1'b0);
    tick();
    chk1("mis_ack", ext_ack, 1'b1);
    chk1("mis_err", ext_err, 1'b1);
    chk("mis_rdata", ext_rdata, 32'h0);
    tick();
    ext_req = 0; ext_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; #1;
    chk("mis_mem_intact", cpu_rdata, 32'h1234_5678);
    tick();

    // Starvation: CPU always requesting, ext re-requests one cycle after each ack
    cpu_addr = 32'h40; ext_we = 0; ext_addr = 32'h44;
    for (int k = 0; k < 13; k++) begin
      ext_req = !last_ack; #1;
      chk1("starve_stall", cpu_stall, exp_stall[k]);
      tick();
    end
    ext_req = 0; cpu_req = 0;
    tick();

    // Reset in the middle of EXT_RESP drops the ack at once
    ext_req = 1; ext_addr = 32'h30;
    tick();
    model_cycle();
    @(negedge clk); #1;
    chk1("rst_pre_ack", ext_ack, 1'b1);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0; cpu_wdata = 32'hBAD0_BAD0;
    reset = 1'b0; #1;
    chk1("rst_ack_drop", ext_ack, 1'b0);
    chk1("rst_dm_we_mid", dm_we, 1'b0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; cpu_we = 0; ext_req = 0;
    tick();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      if (!(cpu_req && last_stall)) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        cpu_wdata = $urandom;
      end
      if (ext_req) begin
        if (last_ack) ext_done = 1;
        if (ext_done && $urandom_range(0, 3) != 0) ext_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ext_req   = 1;
        ext_done  = 0;
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = {22'd0, 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        ext_wdata = $urandom;
      end
      tick();
    end

    cpu_req = 0; ext_req = 0;
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk); #1;
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    chk("ext_q_drained", 32'(ext_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
